// File: rtl/sm_debug_ctrl.sv
// rtl/sm_debug_ctrl.sv - debug run/step/breakpoint controller for the CPU core
module sm_debug_ctrl #(
  parameter int STEP_W = 16,
  parameter int ICNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_cnt,
  input  logic [31:0]       cmd_bp,
  input  logic              rd_req,
  input  logic [4:0]        rd_addr,
  output logic              rd_ready,
  output logic              rd_ack,
  output logic [31:0]       rd_data,
  output logic              cpu_clk_en,
  output logic [4:0]        reg_addr,
  input  logic [31:0]       reg_data,
  output logic              busy,
  output logic              done,
  output logic [ICNT_W-1:0] icount
);

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_RUN_BP = 3'd3,
    S_READ   = 3'd4
  } state_t;

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_BP   = 2'b11;

  localparam logic [STEP_W-1:0] STEP_ZERO = '0;
  localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [ICNT_W-1:0] ICNT_ONE  = {{(ICNT_W-1){1'b0}}, 1'b1};

  state_t            state, stateNext;
  logic [STEP_W-1:0] stepCnt, stepCntNext;
  logic [31:0]       bpReg, bpRegNext;
  logic [4:0]        addrReg, addrRegNext;
  logic              doneNext, ackNext;
  logic [31:0]       rdDataNext;
  logic              cmdFire, rdFire, active;

  // Handshake and status outputs decoded from the current state
  assign cmd_ready = (state != S_READ);
  assign rd_ready  = (state == S_HALT) && !cmd_valid;
  assign cmdFire   = cmd_valid && cmd_ready;
  assign rdFire    = rd_req && rd_ready;
  assign active    = (state == S_RUN) || (state == S_STEP) || (state == S_RUN_BP);
  assign busy      = active;
  assign reg_addr  = (state == S_READ) ? addrReg : 5'd0;
  // In RUN_BP the core is frozen on the cycle its PC matches, so the bp instruction never retires
  assign cpu_clk_en = (state == S_RUN) || (state == S_STEP) ||
                      ((state == S_RUN_BP) && (reg_data != bpReg));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_HALT;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and next datapath values; a new command always preempts the current activity
  always_comb begin
    stateNext   = state;
    stepCntNext = stepCnt;
    bpRegNext   = bpReg;
    addrRegNext = addrReg;
    doneNext    = 1'b0;
    ackNext     = 1'b0;
    rdDataNext  = rd_data;
    if (cmdFire) begin
      case (cmd_op)
        OP_HALT: begin
          stateNext = S_HALT;
          doneNext  = active;
        end
        OP_RUN: begin
          stateNext = S_RUN;
        end
        OP_STEP: begin
          if (cmd_cnt == STEP_ZERO) begin
            stateNext = S_HALT;
            doneNext  = 1'b1;
          end else begin
            stateNext   = S_STEP;
            stepCntNext = cmd_cnt;
          end
        end
        OP_BP: begin
          stateNext = S_RUN_BP;
          bpRegNext = cmd_bp;
        end
        default: stateNext = state;
      endcase
    end else begin
      case (state)
        S_HALT: begin
          if (rdFire) begin
            stateNext   = S_READ;
            addrRegNext = rd_addr;
          end
        end
        S_STEP: begin
          stepCntNext = stepCnt - STEP_ONE;
          if (stepCnt == STEP_ONE) begin
            stateNext = S_HALT;
            doneNext  = 1'b1;
          end
        end
        S_RUN_BP: begin
          if (reg_data == bpReg) begin
            stateNext = S_HALT;
            doneNext  = 1'b1;
          end
        end
        S_READ: begin
          rdDataNext = reg_data;
          ackNext    = 1'b1;
          stateNext  = S_HALT;
        end
        default: stateNext = state;
      endcase
    end
  end

  // Datapath registers, pulses and the retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      stepCnt <= '0;
      bpReg   <= '0;
      addrReg <= '0;
      done    <= 1'b0;
      rd_ack  <= 1'b0;
      rd_data <= '0;
      icount  <= '0;
    end else begin
      stepCnt <= stepCntNext;
      bpReg   <= bpRegNext;
      addrReg <= addrRegNext;
      done    <= doneNext;
      rd_ack  <= ackNext;
      rd_data <= rdDataNext;
      if (cpu_clk_en) begin
        icount <= icount + ICNT_ONE;
      end
    end
  end

endmodule

// File: doc/sm_debug_ctrl.md
SM_DEBUG_CTRL -- requirements
Module: sm_debug_ctrl

Interface
REQ-001 SHALL have parameter STEP_W, default 16: width of the step-count argument.
REQ-002 SHALL have parameter ICNT_W, default 32: width of the retired-instruction counter.
REQ-003 SHALL have port clk, input, 1: single clock, same clock as the CPU core clkIn with the divider bypassed.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1: command offered.
REQ-006 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid && cmd_ready at a clk rising edge.
REQ-007 SHALL have port cmd_op, input, 2: command code; 00 HALT, 01 RUN, 10 STEP, 11 RUN_TO_BP.
REQ-008 SHALL have port cmd_cnt, input, STEP_W: number of instructions for STEP.
REQ-009 SHALL have port cmd_bp, input, 32: breakpoint PC as a word address, for RUN_TO_BP.
REQ-010 SHALL have port rd_req, input, 1: host register-read request.
REQ-011 SHALL have port rd_addr, input, 5: register to read; 0 selects PC.
REQ-012 SHALL have port rd_ready, output, 1: read accepted when rd_req && rd_ready.
REQ-013 SHALL have port rd_ack, output, 1: one-cycle pulse marking rd_data valid.
REQ-014 SHALL have port rd_data, output, 32: captured register value.
REQ-015 SHALL have port cpu_clk_en, output, 1: drives the CPU clkEnable; while high, one instruction retires per clk.
REQ-016 SHALL have port reg_addr, output, 5: drives the CPU regAddr debug port.
REQ-017 SHALL have port reg_data, input, 32: from the CPU regData port; combinational from reg_addr.
REQ-018 SHALL have port busy, output, 1: high in RUN, STEP and RUN_BP.
REQ-019 SHALL have port done, output, 1: one-cycle pulse when the controller returns to HALT from RUN, STEP or RUN_BP.
REQ-020 SHALL have port icount, output, ICNT_W: count of retired instructions.

Function
REQ-021 SHALL implement the states HALT, RUN, STEP, RUN_BP and READ.
REQ-022 cpu_clk_en SHALL be high in RUN and STEP, and in RUN_BP only when reg_data != bp_reg; it SHALL be low in HALT and READ.
REQ-023 cmd_ready SHALL be 1 in every state except READ.
REQ-024 An accepted command SHALL take effect from the next cycle.
REQ-025 HALT command from any state: go to HALT; pulse done only if the previous state was RUN, STEP or RUN_BP.
REQ-026 RUN command: go to RUN; remain there until a HALT command.
REQ-027 STEP command with cmd_cnt = N > 0: go to STEP and load step_cnt = N.
REQ-028 In STEP, each cycle SHALL decrement step_cnt; when step_cnt = 1, go to HALT and pulse done, so exactly N enabled cycles occur.
REQ-029 STEP command with N = 0: stay in HALT and pulse done the next cycle; no instruction executes.
REQ-030 RUN_TO_BP command: latch bp_reg = cmd_bp and go to RUN_BP.
REQ-031 In RUN_BP, reg_addr SHALL be 0 (PC); when reg_data == bp_reg, go to HALT and pulse done, leaving the instruction at bp unexecuted.
REQ-032 If PC already equals bp at entry to RUN_BP, the block SHALL halt after zero instructions.
REQ-033 A command accepted in a non-HALT state SHALL replace the current command: new STEP reloads step_cnt; new RUN_TO_BP reloads bp_reg; no done pulse.
REQ-034 rd_ready SHALL equal (state == HALT) && !cmd_valid; a command wins over a simultaneous read.
REQ-035 An accepted read SHALL latch addr_reg = rd_addr and enter READ.
REQ-036 In READ, reg_addr = addr_reg; at the next edge capture rd_data = reg_data, pulse rd_ack, return to HALT. Latency: ack one cycle after acceptance.
REQ-037 reg_addr SHALL be 0 in all states except READ.
REQ-038 icount SHALL increment on every cycle where cpu_clk_en = 1, and wrap modulo 2^ICNT_W.
REQ-039 rd_data SHALL hold its value between acks.

Reset
REQ-040 On rst: state = HALT; cpu_clk_en = 0, busy = 0, done = 0, rd_ack = 0, rd_data = 0, icount = 0, step_cnt = 0, bp_reg = 0, reg_addr = 0.
REQ-041 rst SHALL override any concurrent command or read, including mid-STEP and mid-READ.
REQ-042 The block's reset SHALL be independent of the CPU rst_n; the CPU stays frozen after rst until a command arrives.

Verification
REQ-043 Reset, then STEP cnt=3 -> cpu_clk_en high exactly 3 cycles, icount=3, done pulses once, busy low afterwards.
REQ-044 Program loop at PC 0..5, RUN_TO_BP bp=4 -> halt with PC (rd_addr=0 read) = 4; STEP cnt=1 -> PC = 5.
REQ-045 Halted with $v0=7, rd_req rd_addr=2 -> rd_ack one cycle later with rd_data=7, reg_addr back to 0.
REQ-046 RUN, then HALT after 10 cycles -> icount=10, done pulse; a rd_req asserted in the same cycle as a cmd_valid is not accepted.
REQ-047 STEP cnt=0 -> done pulse, icount unchanged; rst asserted mid-STEP cnt=100 -> HALT next cycle, icount=0, no done pulse.
REQ-048 With ICNT_W=4, RUN for 17 cycles -> icount=1 (wrap).
